rider_steer_ctrl: RTL
=====================

# rider_steer_ctrl

Parametrised rider-presence and steering-enable controller for the segway balance path. It registers the left/right load-cell readings from the A2D interface and qualifies rider mounting with a settle timer. It enables steering toward balance_cntrl and reports dismount. Compared with the first-generation steering enable, it adds:
- parametrised width and thresholds,
- on/off weight hysteresis,
- a debounced dismount (off) timer,
- a signed load-cell difference output,
- a state status output.

## Interface
Parameters:
- W, 12: load-cell reading width (unsigned).
- MIN_ON, 100: rider-present threshold; sum must be strictly greater.
- MIN_OFF, 80: rider-absent threshold; sum must be strictly less. Legal only if MIN_OFF <= MIN_ON.
- SETTLE_CYC, 65_000_000: number of cycles the rider must be settled before steering enables (1.3 s at 50 MHz). Must be >= 2.
- OFF_CYC, 2_500_000: number of consecutive low-weight cycles before dismount is declared. Must be >= 1.
- SETTLE_SHIFT, 2: "not settled" threshold is sum >> SETTLE_SHIFT (1/4).
- STEPOFF_SHIFT, 4: "stepping off" threshold is sum - (sum >> STEPOFF_SHIFT) (15/16).

Ports:
- clk, in, 1: system clock.
- rst, in, 1: one clock; reset is synchronous and active-high.
- lft_ld, in, W: left load cell, unsigned.
- rght_ld, in, W: right load cell, unsigned.
- ld_cell_diff, out, W+1: registered lft_ld - rght_ld, two's complement.
- en_steer, out, 1: high while state is STEER.
- rider_off, out, 1: one-cycle pulse on return to IDLE.
- state, out, 2: IDLE=0, WAIT=1, STEER=2; 3 is never produced.

## Operation
Input stage:
- lft_ld and rght_ld are registered every cycle into lft_q and rght_q.
- All flags are computed combinationally from lft_q and rght_q.

Arithmetic:
- sum = lft_q + rght_q, W+1 bits, no overflow.
- diff = lft_q - rght_q, W+1 bits signed.
- abs_diff = |diff|, W bits; exact, since the maximum magnitude is 2^W - 1.
- sum_on = sum > MIN_ON.
- sum_off = sum < MIN_OFF.
- unsettled = abs_diff > (sum >> SETTLE_SHIFT).
- stepoff = abs_diff > (sum - (sum >> STEPOFF_SHIFT)).
- ld_cell_diff <= diff every cycle.

Settle timer (settle_cnt, width clog2(SETTLE_CYC)):
- Cleared on the edge that enters WAIT, and on any cycle in WAIT where unsettled is true.
- Otherwise increments while in WAIT.
- settle_full = (settle_cnt == SETTLE_CYC-1).

Off timer (off_cnt, width clog2(OFF_CYC+1)):
- Increments while sum_off is true and state is not IDLE.
- Cleared to 0 whenever sum_off is false or state is IDLE.
- off_full = sum_off and (off_cnt == OFF_CYC-1).

State machine (Moore outputs en_steer and state; priority is top to bottom within each state):
- IDLE: if sum_on, go to WAIT; otherwise stay.
- WAIT:
  - off_full: go to IDLE and pulse rider_off.
  - unsettled: stay and clear settle_cnt.
  - settle_full: go to STEER.
  - otherwise: stay.
- STEER:
  - off_full: go to IDLE and pulse rider_off.
  - stepoff: go to WAIT, which clears settle_cnt.
  - otherwise: stay.

Additional rules:
- rider_off is a registered pulse. It is high exactly in the cycle after the edge that enters IDLE from WAIT or STEER, and never on reset.
- Hysteresis band: when MIN_OFF <= sum <= MIN_ON in WAIT or STEER, the state holds and off_cnt clears.
- A weight dip shorter than OFF_CYC cycles causes no transition. en_steer stays high throughout the dip.

## Timing
- Reset: on an edge with rst=1, all of the following go to 0, overriding everything and including mid-operation:
  - lft_q, rght_q, ld_cell_diff, settle_cnt, off_cnt
  - state (goes to IDLE)
  - en_steer, rider_off
- Mount latency: inputs applied before edge N are registered at N. The state enters WAIT at edge N+1.
- Settle time: WAIT lasts exactly SETTLE_CYC cycles after the last unsettled cycle. en_steer rises SETTLE_CYC edges after WAIT entry if the rider stays settled.
- Dismount latency: sum_off must be seen for OFF_CYC consecutive registered cycles. The state goes to IDLE on the OFF_CYC-th such edge, and rider_off is high in the following cycle.
- ld_cell_diff lags the inputs by 2 edges: input register, then output register.
- Simultaneous off_full and stepoff in STEER: IDLE wins.
- Simultaneous off_full and settle_full in WAIT: IDLE wins.

## Test plan
Bench parameters: W=12, MIN_ON=100, MIN_OFF=80, SETTLE_CYC=16, OFF_CYC=4.
1. Mount and settle: lft=rght=300 held. Expect WAIT 2 edges later and STEER 16 edges after that; en_steer=1; ld_cell_diff=0.
2. Unsettled restart: in WAIT, lft=400, rght=200 (abs_diff 200 > 150) for 5 cycles, then balanced. Expect STEER exactly 16 cycles after the last unsettled registered cycle.
3. Stepoff: in STEER, lft=300, rght=0. stepoff is true (300 > 282), sum_off is false. Expect WAIT, en_steer=0, ld_cell_diff=+300.
4. Hysteresis and debounce: in STEER, sum=90 for 20 cycles gives no change. Then sum=50 for 3 cycles gives no change. Then sum=50 for 4 cycles gives IDLE plus a single rider_off pulse.
5. Negative diff: lft=0, rght=4095. Expect ld_cell_diff=-4095 and abs_diff=4095 with no wrap.
6. Reset mid-STEER: assert rst for 1 cycle. Expect state=IDLE, en_steer=0, rider_off=0 after that edge. Remount then takes the full settle time again.

Source files
------------

// File: rtl/rider_steer_ctrl.sv
// Rider-presence and steering-enable controller: registers load cells, qualifies
// mounting with a settle timer, debounces dismount, and reports a signed L-R difference.
module rider_steer_ctrl #(
  parameter int W             = 12,
  parameter int MIN_ON        = 100,
  parameter int MIN_OFF       = 80,
  parameter int SETTLE_CYC    = 65_000_000,
  parameter int OFF_CYC       = 2_500_000,
  parameter int SETTLE_SHIFT  = 2,
  parameter int STEPOFF_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lft_ld,
  input  logic [W-1:0] rght_ld,
  output logic [W:0]   ld_cell_diff,
  output logic         en_steer,
  output logic         rider_off,
  output logic [1:0]   state
);

  localparam int SW = $clog2(SETTLE_CYC);
  localparam int OW = $clog2(OFF_CYC + 1);
  localparam logic [W:0]    C_MIN_ON      = (W+1)'(MIN_ON);
  localparam logic [W:0]    C_MIN_OFF     = (W+1)'(MIN_OFF);
  localparam logic [SW-1:0] C_SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [OW-1:0] C_OFF_LAST    = OW'(OFF_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STEER = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [W-1:0]  r_lft_q;
  logic [W-1:0]  r_rght_q;
  logic [W:0]    r_ld_cell_diff;
  logic [SW-1:0] r_settle_cnt;
  logic [OW-1:0] r_off_cnt;
  logic          r_rider_off;

  logic [W:0]    w_sum;
  logic [W:0]    w_diff;
  logic [W:0]    w_abs_diff;
  logic          w_sum_on;
  logic          w_sum_off;
  logic          w_unsettled;
  logic          w_stepoff;
  logic          w_settle_full;
  logic          w_off_full;
  logic [SW-1:0] w_settle_nxt;
  logic [OW-1:0] w_off_nxt;

  // abs_diff is kept one bit wide so the negation of -(2^W-1) stays exact
  assign w_sum         = {1'b0, r_lft_q} + {1'b0, r_rght_q};
  assign w_diff        = {1'b0, r_lft_q} - {1'b0, r_rght_q};
  assign w_abs_diff    = w_diff[W] ? ((W+1)'(0) - w_diff) : w_diff;
  assign w_sum_on      = w_sum > C_MIN_ON;
  assign w_sum_off     = w_sum < C_MIN_OFF;
  assign w_unsettled   = w_abs_diff > (w_sum >> SETTLE_SHIFT);
  assign w_stepoff     = w_abs_diff > (w_sum - (w_sum >> STEPOFF_SHIFT));
  assign w_settle_full = (r_settle_cnt == C_SETTLE_LAST);
  assign w_off_full    = w_sum_off && (r_off_cnt == C_OFF_LAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sum_on) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_off_full)         w_next = S_IDLE;
        else if (w_unsettled)   w_next = S_WAIT;
        else if (w_settle_full) w_next = S_STEER;
      end
      S_STEER: begin
        if (w_off_full)     w_next = S_IDLE;
        else if (w_stepoff) w_next = S_WAIT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // settle_cnt idles at zero outside WAIT, so every WAIT entry starts from zero
  always_comb begin
    w_settle_nxt = '0;
    if (r_state == S_WAIT && !w_unsettled) w_settle_nxt = r_settle_cnt + SW'(1);
    w_off_nxt = '0;
    if (w_sum_off && r_state != S_IDLE) w_off_nxt = r_off_cnt + OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lft_q        <= '0;
      r_rght_q       <= '0;
      r_ld_cell_diff <= '0;
      r_settle_cnt   <= '0;
      r_off_cnt      <= '0;
      r_rider_off    <= 1'b0;
      r_state        <= S_IDLE;
    end else begin
      r_lft_q        <= lft_ld;
      r_rght_q       <= rght_ld;
      r_ld_cell_diff <= w_diff;
      r_settle_cnt   <= w_settle_nxt;
      r_off_cnt      <= w_off_nxt;
      r_rider_off    <= (r_state != S_IDLE) && (w_next == S_IDLE);
      r_state        <= w_next;
    end
  end

  assign ld_cell_diff = r_ld_cell_diff;
  assign en_steer     = (r_state == S_STEER);
  assign rider_off    = r_rider_off;
  assign state        = r_state;

endmodule
